i2c_slave_regfile: RTL and testbench
====================================

Name: i2c_slave_regfile

Overview:
Synthesizable, parametrised I2C target: the hardware successor to the fixed 4-byte write-only slave model. It adds 7-bit address matching, a register pointer, multi-byte write and read with auto-increment, and an internal register file. Sits beside i2c_controller in benches and ships as an FPGA IP target, with a user-side port for local register access.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit device address matched against the first byte.
NUM_REG, 8, number of BYTE_SIZE-bit registers (power of 2, 2..256).
BYTE_SIZE, 8, data byte width; the address byte is always 8 bits.
SYNC_STAGES, 2, synchronizer flops on SCL and SDA (2..4).

Ports:
clk  input  1  system clock; must be at least 20x the SCL frequency.
resetn  input  1  asynchronous, active-low reset.
i2c_SCL  input  1  I2C clock from master.
i2c_SDA  inout  1  open-drain data; drives 0 or releases to z.
usr_we  input  1  user register write strobe.
usr_addr  input  clog2(NUM_REG)  user register address (read and write).
usr_wdata  input  BYTE_SIZE  user write data.
usr_rdata  output  BYTE_SIZE  combinational read of reg[usr_addr].
wr_valid  output  1  1-cycle pulse when an I2C write updates a register.
wr_addr  output  clog2(NUM_REG)  register written by I2C.
wr_data  output  BYTE_SIZE  data written by I2C.
busy  output  1  high from START until STOP, NACK exit, or address mismatch.

Behaviour:
- Reset: all registers, pointer, wr_valid, wr_addr, wr_data and busy go to 0; SDA released; state IDLE.
- SCL and SDA pass through SYNC_STAGES flops; edges are detected on the synchronized signals.
- START (SDA falls while SCL high): enter ADDR from any state. Latency is SYNC_STAGES+1 clk.
- STOP (SDA rises while SCL high): go to IDLE from any state and release SDA. A partial byte is discarded.
- Bits are sampled on the synchronized SCL rising edge, MSB first.
- SDA is changed only one clk after a synchronized SCL falling edge.
- ADDR: after 8 bits, compare bits[7:1] with SLAVE_ADDR.
  - Match: ACK. Then go to PTR if R/W=0, or to RDATA if R/W=1.
  - Mismatch: no ACK; go to IDLE and clear busy.
- PTR: the first write byte is the register pointer.
  - If the value is below NUM_REG: ACK, load the pointer, go to WDATA.
  - Otherwise: NACK and go to IDLE.
- WDATA: each received byte is written to reg[ptr], wr_valid pulses, then ACK.
  - ptr increments and wraps from NUM_REG-1 to 0.
- RDATA: the shift register loads reg[ptr] at the SCL falling edge that ends the ACK slot.
  - Drive each bit; after 8 bits release SDA and sample the master ACK on the next SCL rise.
  - ptr increments (with wrap) after every transmitted byte.
  - Master ACK continues to the next byte. Master NACK goes to IDLE; wait for STOP or START.
- ACK drive: pull SDA low from the SCL fall after bit 8 to the following SCL fall.
- Repeated START mid-transfer returns to ADDR. The pointer is kept, so write-pointer-then-read works.
- Simultaneous usr_we and I2C write to the same register in the same clk: the I2C write wins. usr_we to other registers is unaffected.
- Reset asserted mid-transaction: SDA is released immediately (asynchronously).

Optional Feature:
I2C_GEN_CALL_EN
- Defined: address byte 8'h00 (general call, write) is ACKed and handled as a write transaction, identical to a SLAVE_ADDR write. Address 8'h01 is NACKed.
- Undefined: 8'h00 is treated as an ordinary address mismatch.

Test Plan:
- Write SLAVE_ADDR, ptr 0x02, data A1 B2 C3 D4 -> all 6 bytes ACKed; reg2..5 = A1,B2,C3,D4; 4 wr_valid pulses.
- Write ptr 0x02, repeated START, read 4 bytes with ACK,ACK,ACK,NACK -> master receives A1 B2 C3 D4; SDA released after the NACK.
- Address 7'h51 -> 9th-bit SDA stays high; busy drops; no register changes.
- ptr 0x06 with NUM_REG=8, write 11 22 33 -> reg6=11, reg7=22, reg0=33 (wrap).
- ptr 0x09 -> NACK on the pointer byte; no register changes.
- STOP after 5 data bits -> no write; IDLE.
- resetn low mid-read -> SDA immediately z; all registers 0.
- usr_we to reg3 = 5A -> I2C read of ptr 3 returns 5A.
- With I2C_GEN_CALL_EN defined: address 8'h00 is ACKed and subsequent writes land.
- Without I2C_GEN_CALL_EN: address 8'h00 is NACKed.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target with 7-bit address match, register pointer,
// auto-incrementing multi-byte write/read and a local user-side register port.
// Optional feature: define I2C_GEN_CALL_EN to accept the general-call address
// (8'h00) as a write transaction.
`timescale 1ns/1ps

module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         NUM_REG     = 8,
    parameter int         BYTE_SIZE   = 8,
    parameter int         SYNC_STAGES = 2,
    localparam int        AW          = (NUM_REG > 1) ? $clog2(NUM_REG) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i2c_SCL,
    inout  wire                  i2c_SDA,
    input  logic                 usr_we,
    input  logic [AW-1:0]        usr_addr,
    input  logic [BYTE_SIZE-1:0] usr_wdata,
    output logic [BYTE_SIZE-1:0] usr_rdata,
    output logic                 wr_valid,
    output logic [AW-1:0]        wr_addr,
    output logic [BYTE_SIZE-1:0] wr_data,
    output logic                 busy
);

    // Shift register must hold both the 8-bit address byte and a data byte.
    localparam int SW = (BYTE_SIZE > 8) ? BYTE_SIZE : 8;
    localparam int CW = $clog2(SW + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK
    } state_t;

    logic [SYNC_STAGES-1:0] scl_pipe, sda_pipe;
    logic                   scl_s, sda_s, scl_d, sda_d;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t         state, state_nx;
    logic [SW-1:0]  shift, shift_nx;
    logic [CW-1:0]  bit_cnt, bit_cnt_nx;
    logic [AW-1:0]  ptr, ptr_nx;
    logic           sda_low, sda_low_nx;
    logic           busy_nx;
    logic           rd_mode, rd_mode_nx;

    logic                 i2c_we;
    logic [AW-1:0]        i2c_waddr;
    logic [BYTE_SIZE-1:0] i2c_wdata;
    logic [BYTE_SIZE-1:0] rd_byte;
    logic                 addr_hit, gen_call_hit, ptr_ok;

    logic [BYTE_SIZE-1:0] regs [NUM_REG];

    // Bring the bus lines into the clk domain; idle bus level is high so reset to 1
    // to avoid a false START/STOP right after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], i2c_SCL};
            sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], i2c_SDA};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_pipe[SYNC_STAGES-1];
    assign sda_s     = sda_pipe[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

`ifdef I2C_GEN_CALL_EN
    assign gen_call_hit = (shift[7:0] == 8'h00);
`else
    assign gen_call_hit = 1'b0;
`endif
    assign addr_hit = (shift[7:1] == SLAVE_ADDR) || gen_call_hit;
    assign ptr_ok   = (32'(shift[BYTE_SIZE-1:0]) < 32'(NUM_REG));
    assign rd_byte  = regs[ptr];

    // Protocol engine: all SDA updates are decided on a synchronized SCL fall so
    // the line changes one clk later, while SCL is low.
    always_comb begin
        state_nx   = state;
        shift_nx   = shift;
        bit_cnt_nx = bit_cnt;
        ptr_nx     = ptr;
        sda_low_nx = sda_low;
        busy_nx    = busy;
        rd_mode_nx = rd_mode;
        i2c_we     = 1'b0;
        i2c_waddr  = ptr;
        i2c_wdata  = shift[BYTE_SIZE-1:0];

        if (stop_det) begin
            state_nx   = S_IDLE;
            busy_nx    = 1'b0;
            sda_low_nx = 1'b0;
            bit_cnt_nx = '0;
        end else if (start_det) begin
            state_nx   = S_ADDR;
            busy_nx    = 1'b1;
            sda_low_nx = 1'b0;
            bit_cnt_nx = '0;
        end else begin
            case (state)
                S_ADDR: begin
                    if (scl_rise && bit_cnt < CW'(8)) begin
                        shift_nx   = {shift[SW-2:0], sda_s};
                        bit_cnt_nx = bit_cnt + CW'(1);
                    end else if (scl_fall && bit_cnt == CW'(8)) begin
                        if (addr_hit) begin
                            sda_low_nx = 1'b1;
                            rd_mode_nx = shift[0];
                            state_nx   = S_ADDR_ACK;
                        end else begin
                            state_nx = S_IDLE;
                            busy_nx  = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_nx = '0;
                        if (rd_mode) begin
                            shift_nx   = SW'(rd_byte);
                            sda_low_nx = ~rd_byte[BYTE_SIZE-1];
                            state_nx   = S_RDATA;
                        end else begin
                            sda_low_nx = 1'b0;
                            state_nx   = S_PTR;
                        end
                    end
                end
                S_PTR: begin
                    if (scl_rise && bit_cnt < CW'(BYTE_SIZE)) begin
                        shift_nx   = {shift[SW-2:0], sda_s};
                        bit_cnt_nx = bit_cnt + CW'(1);
                    end else if (scl_fall && bit_cnt == CW'(BYTE_SIZE)) begin
                        if (ptr_ok) begin
                            ptr_nx     = AW'(shift[BYTE_SIZE-1:0]);
                            sda_low_nx = 1'b1;
                            state_nx   = S_PTR_ACK;
                        end else begin
                            state_nx = S_IDLE;
                            busy_nx  = 1'b0;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_low_nx = 1'b0;
                        bit_cnt_nx = '0;
                        state_nx   = S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (scl_rise && bit_cnt < CW'(BYTE_SIZE)) begin
                        shift_nx   = {shift[SW-2:0], sda_s};
                        bit_cnt_nx = bit_cnt + CW'(1);
                    end else if (scl_fall && bit_cnt == CW'(BYTE_SIZE)) begin
                        i2c_we     = 1'b1;
                        ptr_nx     = ptr + AW'(1);
                        sda_low_nx = 1'b1;
                        state_nx   = S_WDATA_ACK;
                    end
                end
                S_RDATA: begin
                    if (scl_rise && bit_cnt < CW'(BYTE_SIZE)) begin
                        bit_cnt_nx = bit_cnt + CW'(1);
                    end else if (scl_fall && bit_cnt == CW'(BYTE_SIZE)) begin
                        sda_low_nx = 1'b0;
                        ptr_nx     = ptr + AW'(1);
                        bit_cnt_nx = '0;
                        state_nx   = S_RDATA_ACK;
                    end else if (scl_fall && bit_cnt != '0) begin
                        shift_nx   = shift << 1;
                        sda_low_nx = ~shift[BYTE_SIZE-2];
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_nx = S_IDLE;
                            busy_nx  = 1'b0;
                        end else begin
                            bit_cnt_nx = CW'(1);
                        end
                    end else if (scl_fall && bit_cnt == CW'(1)) begin
                        shift_nx   = SW'(rd_byte);
                        sda_low_nx = ~rd_byte[BYTE_SIZE-1];
                        bit_cnt_nx = '0;
                        state_nx   = S_RDATA;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Protocol engine state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            ptr     <= '0;
            sda_low <= 1'b0;
            busy    <= 1'b0;
            rd_mode <= 1'b0;
        end else begin
            state   <= state_nx;
            shift   <= shift_nx;
            bit_cnt <= bit_cnt_nx;
            ptr     <= ptr_nx;
            sda_low <= sda_low_nx;
            busy    <= busy_nx;
            rd_mode <= rd_mode_nx;
        end
    end

    // Register file; the I2C write is applied last so it wins a same-address clash.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs[i] <= '0;
            end
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_valid <= i2c_we;
            if (i2c_we) begin
                wr_addr <= i2c_waddr;
                wr_data <= i2c_wdata;
            end
            if (usr_we) begin
                regs[usr_addr] <= usr_wdata;
            end
            if (i2c_we) begin
                regs[i2c_waddr] <= i2c_wdata;
            end
        end
    end

    assign usr_rdata = regs[usr_addr];

    // Open-drain output; reset gates the driver so SDA is released at once.
    assign i2c_SDA = (sda_low && resetn) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed testbench for i2c_slave_regfile: a behavioural bus master drives
// SCL/SDA, expected values are hand-computed per scenario.
`timescale 1ns/1ps

module tb_i2c_slave_regfile;

    localparam time Q = 100;

    logic       clk = 1'b0;
    logic       resetn;
    logic       scl;
    logic       m_low;
    wire        sda;
    logic       usr_we;
    logic [2:0] usr_addr;
    logic [7:0] usr_wdata;
    logic [7:0] usr_rdata;
    logic       wr_valid;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;

    pullup(sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_slave_regfile dut (
        .clk       (clk),
        .resetn    (resetn),
        .i2c_SCL   (scl),
        .i2c_SDA   (sda),
        .usr_we    (usr_we),
        .usr_addr  (usr_addr),
        .usr_wdata (usr_wdata),
        .usr_rdata (usr_rdata),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    // 100 MHz system clock; SCL period is 4*Q = 400 ns (40 clk).
    always #5 clk = ~clk;

    // Count I2C write pulses for later comparison.
    always @(posedge clk) begin
        if (wr_valid) wr_cnt++;
    end

    // Safety net so the run can never hang.
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        resetn = 1'b0; scl = 1'b1; m_low = 1'b0;
        usr_we = 1'b0; usr_addr = '0; usr_wdata = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
    endtask

    task automatic write_bit(input logic b);
        m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = (b === 1'b0);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_valid: got %b expected 0", wr_valid); end
        checks++; if (sda !== 1'b1) begin errors++; $display("[TB] FAIL reset_sda: got %b expected 1", sda); end
        for (int r = 0; r < 8; r++) begin
            usr_addr = 3'(r); #1;
            checks++; if (usr_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h expected 00", r, usr_rdata); end
        end
    endtask

    task automatic test_start_latency();
        @(posedge clk); #2 m_low = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL start_early: got %b expected 0", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL start_latency: got %b expected 1", busy); end
        #Q; scl = 1'b0; #Q;
        i2c_stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stop_busy: got %b expected 0", busy); end
    endtask

    task automatic test_write();
        logic       ack;
        logic [7:0] wd [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        int         base = wr_cnt;
        int         nack = 0;
        i2c_start();
        write_byte(8'hA0, ack); if (!ack) nack++;
        write_byte(8'h02, ack); if (!ack) nack++;
        for (int i = 0; i < 4; i++) begin
            write_byte(wd[i], ack); if (!ack) nack++;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL write_busy: got %b expected 1", busy); end
        i2c_stop();
        checks++; if (nack !== 0) begin errors++; $display("[TB] FAIL write_acks: got %0d nacks expected 0", nack); end
        checks++; if (wr_cnt - base !== 4) begin errors++; $display("[TB] FAIL write_pulses: got %0d expected 4", wr_cnt - base); end
        checks++; if (wr_addr !== 3'd5 || wr_data !== 8'hD4) begin errors++; $display("[TB] FAIL write_last: got %0d/%h expected 5/d4", wr_addr, wr_data); end
        for (int i = 0; i < 4; i++) begin
            usr_addr = 3'(i + 2); #1;
            checks++; if (usr_rdata !== wd[i]) begin errors++; $display("[TB] FAIL write_reg%0d: got %h expected %h", i + 2, usr_rdata, wd[i]); end
        end
    endtask

    task automatic test_read_rstart();
        logic       ack;
        logic [7:0] rd;
        logic [7:0] exp_d [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h02, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        checks++; if (!ack) begin errors++; $display("[TB] FAIL read_addr_ack: got nack expected ack"); end
        for (int i = 0; i < 4; i++) begin
            read_byte(rd, i < 3);
            checks++; if (rd !== exp_d[i]) begin errors++; $display("[TB] FAIL read_byte%0d: got %h expected %h", i, rd, exp_d[i]); end
        end
        checks++; if (sda !== 1'b1) begin errors++; $display("[TB] FAIL read_release: got %b expected 1", sda); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL read_nack_busy: got %b expected 0", busy); end
        i2c_stop();
    endtask

    task automatic test_addr_mismatch();
        logic ack;
        int   base = wr_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        checks++; if (ack) begin errors++; $display("[TB] FAIL mismatch_ack: got ack expected nack"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mismatch_busy: got %b expected 0", busy); end
        write_byte(8'h02, ack);
        write_byte(8'h99, ack);
        i2c_stop();
        checks++; if (wr_cnt - base !== 0) begin errors++; $display("[TB] FAIL mismatch_writes: got %0d expected 0", wr_cnt - base); end
        usr_addr = 3'd2; #1;
        checks++; if (usr_rdata !== 8'hA1) begin errors++; $display("[TB] FAIL mismatch_reg2: got %h expected a1", usr_rdata); end
    endtask

    task automatic test_wrap();
        logic       ack;
        int         nack = 0;
        logic [7:0] wd [3] = '{8'h11, 8'h22, 8'h33};
        logic [2:0] wa [3] = '{3'd6, 3'd7, 3'd0};
        i2c_start();
        write_byte(8'hA0, ack); if (!ack) nack++;
        write_byte(8'h06, ack); if (!ack) nack++;
        for (int i = 0; i < 3; i++) begin
            write_byte(wd[i], ack); if (!ack) nack++;
        end
        i2c_stop();
        checks++; if (nack !== 0) begin errors++; $display("[TB] FAIL wrap_acks: got %0d nacks expected 0", nack); end
        for (int i = 0; i < 3; i++) begin
            usr_addr = wa[i]; #1;
            checks++; if (usr_rdata !== wd[i]) begin errors++; $display("[TB] FAIL wrap_reg%0d: got %h expected %h", wa[i], usr_rdata, wd[i]); end
        end
    endtask

    task automatic test_bad_ptr();
        logic ack;
        int   base = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h09, ack);
        checks++; if (ack) begin errors++; $display("[TB] FAIL badptr_ack: got ack expected nack"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL badptr_busy: got %b expected 0", busy); end
        i2c_stop();
        checks++; if (wr_cnt - base !== 0) begin errors++; $display("[TB] FAIL badptr_writes: got %0d expected 0", wr_cnt - base); end
    endtask

    task automatic test_partial_stop();
        logic ack;
        int   base = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h00, ack);
        for (int i = 0; i < 5; i++) write_bit(1'b1);
        i2c_stop();
        checks++; if (wr_cnt - base !== 0) begin errors++; $display("[TB] FAIL partial_writes: got %0d expected 0", wr_cnt - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL partial_busy: got %b expected 0", busy); end
        usr_addr = 3'd0; #1;
        checks++; if (usr_rdata !== 8'h33) begin errors++; $display("[TB] FAIL partial_reg0: got %h expected 33", usr_rdata); end
    endtask

    task automatic test_usr_write();
        logic       ack;
        logic [7:0] rd;
        @(posedge clk); #1;
        usr_addr = 3'd3; usr_wdata = 8'h5A; usr_we = 1'b1;
        @(posedge clk); #1 usr_we = 1'b0;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h03, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        read_byte(rd, 1'b0);
        i2c_stop();
        checks++; if (rd !== 8'h5A) begin errors++; $display("[TB] FAIL usr_read: got %h expected 5a", rd); end
    endtask

    task automatic test_collision();
        logic ack;
        logic seen = 1'b0;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h04, ack);
        usr_addr = 3'd4; usr_wdata = 8'hEE; usr_we = 1'b1;
        fork
            write_byte(8'h77, ack);
            begin
                for (int c = 0; c < 2000; c++) begin
                    @(posedge clk); #1;
                    if (wr_valid) begin seen = 1'b1; break; end
                end
                usr_we = 1'b0;
            end
        join
        i2c_stop();
        checks++; if (!seen) begin errors++; $display("[TB] FAIL collide_pulse: got none expected wr_valid"); end
        usr_addr = 3'd4; #1;
        checks++; if (usr_rdata !== 8'h77) begin errors++; $display("[TB] FAIL collide_reg4: got %h expected 77", usr_rdata); end
    endtask

    task automatic test_gen_call();
        logic ack;
        int   base = wr_cnt;
        i2c_start();
        write_byte(8'h00, ack);
`ifdef I2C_GEN_CALL_EN
        checks++; if (!ack) begin errors++; $display("[TB] FAIL gencall_ack: got nack expected ack"); end
        write_byte(8'h01, ack);
        write_byte(8'h5C, ack);
        i2c_stop();
        usr_addr = 3'd1; #1;
        checks++; if (usr_rdata !== 8'h5C) begin errors++; $display("[TB] FAIL gencall_reg1: got %h expected 5c", usr_rdata); end
`else
        checks++; if (ack) begin errors++; $display("[TB] FAIL gencall_ack: got ack expected nack"); end
        i2c_stop();
        checks++; if (wr_cnt - base !== 0) begin errors++; $display("[TB] FAIL gencall_writes: got %0d expected 0", wr_cnt - base); end
`endif
        i2c_start();
        write_byte(8'h01, ack);
        i2c_stop();
        checks++; if (ack) begin errors++; $display("[TB] FAIL addr01_ack: got ack expected nack"); end
    endtask

    task automatic test_reset_mid_read();
        logic ack;
        logic b;
        @(posedge clk); #1;
        usr_addr = 3'd0; usr_wdata = 8'hA1; usr_we = 1'b1;
        @(posedge clk); #1 usr_we = 1'b0;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        read_bit(b);
        checks++; if (sda !== 1'b0) begin errors++; $display("[TB] FAIL midread_drive: got %b expected 0", sda); end
        resetn = 1'b0; #1;
        checks++; if (sda !== 1'b1) begin errors++; $display("[TB] FAIL midread_release: got %b expected 1", sda); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midread_busy: got %b expected 0", busy); end
        usr_addr = 3'd0; #1;
        checks++; if (usr_rdata !== 8'h00) begin errors++; $display("[TB] FAIL midread_reg0: got %h expected 00", usr_rdata); end
        usr_addr = 3'd2; #1;
        checks++; if (usr_rdata !== 8'h00) begin errors++; $display("[TB] FAIL midread_reg2: got %h expected 00", usr_rdata); end
        do_reset();
    endtask

    // Scenario sequence.
    initial begin
        $display("[TB] starting i2c_slave_regfile bench");
        test_reset();
        test_start_latency();
        test_write();
        test_read_rstart();
        test_addr_mismatch();
        test_wrap();
        test_bad_ptr();
        test_partial_stop();
        test_usr_write();
        test_collision();
        test_gen_call();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
